// File: rtl/regfile_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_write_queue                                           |
// | Purpose  : Write-side queue for the 32x32 MIPS register file. It drains  |
// |            one write per cycle and forwards read bypass data for writes  |
// |            that are still pending.                                       |
// | Option   : REGFILE_WQ_OVERFLOW_EN adds a sticky Overflow output.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EnqValid,
  input  logic [4:0]  EnqRegister,
  input  logic [31:0] EnqData,
  output logic        EnqReady,
  input  logic        Hold,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Bypass1Hit,
  output logic [31:0] Bypass1Data,
  output logic        Bypass2Hit,
  output logic [31:0] Bypass2Data,
  output logic        Empty
`ifdef REGFILE_WQ_OVERFLOW_EN
  ,
  output logic        Overflow
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_fullCount = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_entryValid;
  logic [4:0]       w_entryReg  [DEPTH];
  logic [31:0]      w_entryData [DEPTH];

  logic             w_enqStore;
  logic             w_deq;
  logic [4:0]       w_headReg;
  logic [31:0]      w_headData;

  assign EnqReady = (r_count != c_fullCount);
  // Register 0 writes are accepted for flow control but never stored.
  assign w_enqStore = EnqValid && EnqReady && (EnqRegister != 5'd0);
  assign w_deq      = (r_count != '0) && !Hold;
  assign w_headReg  = w_entryReg[r_rdPtr];
  assign w_headData = w_entryData[r_rdPtr];

  // Storage slots; a slot cannot load and clear at once since that needs a full queue.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic        r_valid;
    logic [4:0]  r_reg;
    logic [31:0] r_data;
    logic        w_load;
    logic        w_clear;

    assign w_load  = w_enqStore && (r_wrPtr == PTR_W'(i));
    assign w_clear = w_deq && (r_rdPtr == PTR_W'(i));

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_valid <= 1'b0;
        r_reg   <= 5'd0;
        r_data  <= 32'd0;
      end else begin
        if (w_load) begin
          r_valid <= 1'b1;
          r_reg   <= EnqRegister;
          r_data  <= EnqData;
        end else if (w_clear) begin
          r_valid <= 1'b0;
        end
      end
    end

    assign w_entryValid[i] = r_valid;
    assign w_entryReg[i]   = r_reg;
    assign w_entryData[i]  = r_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_enqStore) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_enqStore, w_deq})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage feeding the regfile write port; address and data hold when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else if (w_deq) begin
      RegWrite      <= 1'b1;
      WriteRegister <= w_headReg;
      WriteData     <= w_headData;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  assign Empty = (r_count == '0) && !RegWrite;

  logic [4:0]       w_rdAddr  [2];
  logic             w_hit     [2];
  logic [31:0]      w_hitData [2];
  logic [PTR_W-1:0] w_slot;

  assign w_rdAddr[0] = ReadRegister1;
  assign w_rdAddr[1] = ReadRegister2;

  // Walk oldest to youngest so the youngest match overrides; output stage is oldest.
  always_comb begin
    w_slot = '0;
    for (int p = 0; p < 2; p++) begin
      w_hit[p]     = 1'b0;
      w_hitData[p] = 32'd0;
      if (w_rdAddr[p] != 5'd0) begin
        if (RegWrite && (WriteRegister == w_rdAddr[p])) begin
          w_hit[p]     = 1'b1;
          w_hitData[p] = WriteData;
        end
        for (int k = 0; k < DEPTH; k++) begin
          w_slot = r_rdPtr + PTR_W'(k);
          if (w_entryValid[w_slot] && (w_entryReg[w_slot] == w_rdAddr[p])) begin
            w_hit[p]     = 1'b1;
            w_hitData[p] = w_entryData[w_slot];
          end
        end
      end
    end
  end

  assign Bypass1Hit  = w_hit[0];
  assign Bypass1Data = w_hitData[0];
  assign Bypass2Hit  = w_hit[1];
  assign Bypass2Data = w_hitData[1];

`ifdef REGFILE_WQ_OVERFLOW_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Overflow <= 1'b0;
    end else if (EnqValid && !EnqReady && (EnqRegister != 5'd0)) begin
      Overflow <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// Testbench for regfile_write_queue: directed cases plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        EnqValid = 1'b0;
  logic [4:0]  EnqRegister = 5'd0;
  logic [31:0] EnqData = 32'd0;
  logic        EnqReady;
  logic        Hold = 1'b0;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  ReadRegister1 = 5'd0;
  logic [4:0]  ReadRegister2 = 5'd0;
  logic        Bypass1Hit;
  logic [31:0] Bypass1Data;
  logic        Bypass2Hit;
  logic [31:0] Bypass2Data;
  logic        Empty;
`ifdef REGFILE_WQ_OVERFLOW_EN
  logic        Overflow;
`endif

  regfile_write_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .EnqValid(EnqValid), .EnqRegister(EnqRegister), .EnqData(EnqData), .EnqReady(EnqReady),
    .Hold(Hold),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Bypass1Hit(Bypass1Hit), .Bypass1Data(Bypass1Data),
    .Bypass2Hit(Bypass2Hit), .Bypass2Data(Bypass2Data),
    .Empty(Empty)
`ifdef REGFILE_WQ_OVERFLOW_EN
    , .Overflow(Overflow)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile driven by the DUT write port.
  logic [31:0] tbRf [32];
  always @(posedge Clk) if (RegWrite) tbRf[WriteRegister] <= WriteData;

  // Behavioural model: pending writes in arrival order plus one in-flight write.
  typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;
  wr_t         mq[$];
  bit          mOutValid = 1'b0;
  logic [4:0]  mOutReg = 5'd0;
  logic [31:0] mOutData = 32'd0;
  logic [31:0] mRf [32];
  bit          mOvf = 1'b0;
  bit          mReady;
  wr_t         mHead;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      mOutValid = 1'b0;
      mOutReg   = 5'd0;
      mOutData  = 32'd0;
      mOvf      = 1'b0;
    end else begin
      mReady = (mq.size() != DEPTH);
      if (mOutValid) mRf[mOutReg] = mOutData;
      if (mq.size() > 0 && !Hold) begin
        mHead     = mq.pop_front();
        mOutValid = 1'b1;
        mOutReg   = mHead.r;
        mOutData  = mHead.d;
      end else begin
        mOutValid = 1'b0;
      end
      if (EnqValid && mReady && EnqRegister != 5'd0) mq.push_back({EnqRegister, EnqData});
      if (EnqValid && !mReady && EnqRegister != 5'd0) mOvf = 1'b1;
    end
  end

  function automatic void lookup(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (a == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == a) begin
        hit = 1'b1;
        d   = mq[i].d;
        return;
      end
    end
    if (mOutValid && mOutReg == a) begin
      hit = 1'b1;
      d   = mOutData;
    end
  endfunction

  bit          h1, h2;
  logic [31:0] d1, d2;

  always @(negedge Clk) begin
    if (checkEn) begin
      chk("EnqReady", EnqReady, mq.size() != DEPTH);
      chk("Empty", Empty, (mq.size() == 0) && !mOutValid);
      chk("RegWrite", RegWrite, mOutValid);
      chk("WriteRegister", WriteRegister, mOutReg);
      chk("WriteData", WriteData, mOutData);
      lookup(ReadRegister1, h1, d1);
      lookup(ReadRegister2, h2, d2);
      chk("Bypass1Hit", Bypass1Hit, h1);
      chk("Bypass2Hit", Bypass2Hit, h2);
      if (h1) chk("Bypass1Data", Bypass1Data, d1);
      if (h2) chk("Bypass2Data", Bypass2Data, d2);
      chk("ArchRead1", Bypass1Hit ? Bypass1Data : tbRf[ReadRegister1], h1 ? d1 : mRf[ReadRegister1]);
      chk("ArchRead2", Bypass2Hit ? Bypass2Data : tbRf[ReadRegister2], h2 ? d2 : mRf[ReadRegister2]);
`ifdef REGFILE_WQ_OVERFLOW_EN
      chk("Overflow", Overflow, mOvf);
`endif
    end
  end

  task automatic drive(input bit v, input logic [4:0] r, input logic [31:0] d, input bit h,
                       input logic [4:0] a1, input logic [4:0] a2);
    EnqValid = v; EnqRegister = r; EnqData = d; Hold = h;
    ReadRegister1 = a1; ReadRegister2 = a2;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbRf[i] = 32'd0;
      mRf[i]  = 32'd0;
    end
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_EnqReady", EnqReady, 1);
    chk("rst_Empty", Empty, 1);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_WriteRegister", WriteRegister, 0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_Bypass1Hit", Bypass1Hit, 0);
    chk("rst_Bypass1Data", Bypass1Data, 0);
    Reset = 1'b0;
    checkEn = 1'b1;

    // Single write latency.
    drive(1, 5'd5, 32'h2A, 0, 5'd5, 5'd0);
    chk("lat_RegWriteEarly", RegWrite, 0);
    chk("lat_PendHit", Bypass1Hit, 1);
    chk("lat_PendData", Bypass1Data, 32'h2A);
    drive(0, 5'd0, 32'd0, 0, 5'd5, 5'd0);
    chk("lat_RegWrite", RegWrite, 1);
    chk("lat_WriteRegister", WriteRegister, 5);
    chk("lat_WriteData", WriteData, 32'h2A);
    drive(0, 5'd0, 32'd0, 0, 5'd5, 5'd0);
    chk("lat_rf5", tbRf[5], 32'h2A);
    chk("lat_Empty", Empty, 1);
    chk("lat_RegWriteOff", RegWrite, 0);

    // Fill under Hold, reject a fifth, then drain in order.
    for (int i = 1; i <= 4; i++) drive(1, 5'(i), 32'(i * 'h11), 1, 5'd0, 5'd0);
    chk("fill_EnqReady", EnqReady, 0);
    drive(1, 5'd9, 32'h99, 1, 5'd9, 5'd0);
    chk("fill_Rejected", Bypass1Hit, 0);
`ifdef REGFILE_WQ_OVERFLOW_EN
    chk("fill_Overflow", Overflow, 1);
`endif
    for (int k = 0; k < 4; k++) begin
      drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
      chk("drain_RegWrite", RegWrite, 1);
      chk("drain_WriteRegister", WriteRegister, 5'(k + 1));
      chk("drain_WriteData", WriteData, 32'((k + 1) * 'h11));
    end
    drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    chk("drain_RegWriteOff", RegWrite, 0);
    chk("drain_Empty", Empty, 1);

    // Newest pending write wins.
    drive(1, 5'd7, 32'hA, 1, 5'd7, 5'd8);
    drive(1, 5'd7, 32'hB, 1, 5'd7, 5'd8);
    chk("byp_Hit1", Bypass1Hit, 1);
    chk("byp_Data1", Bypass1Data, 32'hB);
    chk("byp_Hit2", Bypass2Hit, 0);
    repeat (4) drive(0, 5'd0, 32'd0, 0, 5'd7, 5'd8);

    // Register 0 is dropped.
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0);
    chk("r0_Empty", Empty, 1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    chk("r0_RegWrite", RegWrite, 0);
    chk("r0_Bypass", Bypass1Hit, 0);

    // Steady occupancy of three with simultaneous enqueue and dequeue.
    for (int i = 0; i < 3; i++) drive(1, 5'(10 + i), $urandom, 1, 5'd11, 5'd12);
    for (int i = 0; i < 10; i++) drive(1, 5'(13 + i), $urandom, 0, 5'(13 + i), 5'd12);
    chk("steady_EnqReady", EnqReady, 1);
    chk("steady_Empty", Empty, 0);
    repeat (5) drive(0, 5'd0, 32'd0, 0, 5'd20, 5'd22);

    // Reset mid-operation discards pending writes.
    drive(1, 5'd3, 32'h5555, 1, 5'd3, 5'd4);
    drive(1, 5'd4, 32'h6666, 1, 5'd3, 5'd4);
    EnqValid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("mrst_RegWrite", RegWrite, 0);
    chk("mrst_Empty", Empty, 1);
    chk("mrst_EnqReady", EnqReady, 1);
    chk("mrst_Bypass1Hit", Bypass1Hit, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (4) drive(0, 5'd0, 32'd0, 0, 5'd3, 5'd4);
    chk("mrst_rf3", tbRf[3], 32'h33);
    chk("mrst_rf4", tbRf[4], 32'h44);

    // Randomized traffic with varying hold pressure and occasional resets.
    for (int phase = 0; phase < 3; phase++) begin
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 249) == 0) begin
          Reset = 1'b1;
          @(posedge Clk);
          #1 Reset = 1'b0;
        end
        drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < (phase * 3 + 1),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
    end
    repeat (8) drive(0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    chk("end_Empty", Empty, 1);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
